axi_line_bridge: RTL



---
 rtl/axi_line_bridge_pkg.sv | 25 ++
 rtl/axi_line_bridge_line_beat_mux.sv | 46 ++++
 rtl/axi_line_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_bridge_pkg.sv
// Shared types and constants for the cache-line to AXI4 bridge.
// Optional write-response handling is enabled with the AXI_LINE_BRIDGE_BRESP_EN macro.
package axi_line_bridge_pkg;

  // Controller states; ST_WR_B is only reachable when write responses are checked
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_A,
    ST_WR_D,
    ST_WR_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Number of AXI beats needed to carry one cache line
  function automatic int beats(input int line_w, input int axi_dw);
    return line_w / axi_dw;
  endfunction

endpackage

// File: rtl/axi_line_bridge_line_beat_mux.sv
// Beat slicing for the line bridge: picks the write data/strobe slice for the
// current beat and decodes the per-slice write enable used to assemble reads.
// Slices are addressed by the beat counter; a counter value past the last beat
// selects nothing, so draining extra read beats never corrupts the line.
module line_beat_mux
  import axi_line_bridge_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int AXI_DW = 64,
  parameter int CNT_W  = 3
) (
  input  logic [LINE_W-1:0]        line,
  input  logic [LINE_W/8-1:0]      be,
  input  logic [CNT_W-1:0]         cnt,
  input  logic                     rd_stb,
  output logic [AXI_DW-1:0]        beat_data,
  output logic [AXI_DW/8-1:0]      beat_strb,
  output logic [LINE_W/AXI_DW-1:0] slice_we
);

  localparam int BEATS  = beats(LINE_W, AXI_DW);
  localparam int STRB_W = AXI_DW / 8;

  logic [AXI_DW-1:0] data_slices [BEATS];
  logic [STRB_W-1:0] strb_slices [BEATS];

  genvar gi;
  for (gi = 0; gi < BEATS; gi++) begin : g_slice
    assign data_slices[gi] = line[gi*AXI_DW +: AXI_DW];
    assign strb_slices[gi] = be[gi*STRB_W +: STRB_W];
    assign slice_we[gi]    = rd_stb && (cnt == CNT_W'(gi));
  end

  // Select the write slice addressed by the beat counter
  always_comb begin
    beat_data = '0;
    beat_strb = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt == CNT_W'(i)) begin
        beat_data = data_slices[i];
        beat_strb = strb_slices[i];
      end
    end
  end

endmodule

// File: rtl/axi_line_bridge.sv
// Cache-line request port to AXI4 master bridge for the DDR3 MIG user interface.
// One line becomes one INCR burst of LINE_W/AXI_DW beats; one request in flight.
// Define AXI_LINE_BRIDGE_BRESP_EN to wait for and check the write response;
// otherwise bready is tied high and write responses are ignored.
module axi_line_bridge
  import axi_line_bridge_pkg::*;
#(
  parameter int ADDR_W = 29,
  parameter int LINE_W = 256,
  parameter int AXI_DW = 64,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calib_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [LINE_W-1:0]     req_data_i,
  input  logic [LINE_W/8-1:0]   req_be_i,
  input  logic                  req_rd_i,
  input  logic                  req_we_i,
  output logic                  req_ready_o,
  output logic [LINE_W-1:0]     data_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DW-1:0]     m_axi_wdata,
  output logic [AXI_DW/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_W-1:0]       m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_W-1:0]       m_axi_rid,
  input  logic [AXI_DW-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int BEATS  = beats(LINE_W, AXI_DW);
  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [7:0]       BURST_LEN  = 8'(BEATS - 1);
  localparam logic [2:0]       BURST_SIZE = 3'($clog2(AXI_DW / 8));
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PAST_CNT   = CNT_W'(BEATS);

  state_t                state_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [LINE_W-1:0]     line_reg;
  logic [LINE_W/8-1:0]   be_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  err_reg;
  logic                  ack_reg;
  logic                  ready_reg;
  logic                  arvalid_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  rready_reg;
  logic [AXI_DW-1:0]     rslice_reg [BEATS];
  logic [BEATS-1:0]      slice_we;
  logic                  rd_stb;

  assign rd_stb = (state_reg == ST_RD_D) && rready_reg && m_axi_rvalid;

  line_beat_mux #(
    .LINE_W (LINE_W),
    .AXI_DW (AXI_DW),
    .CNT_W  (CNT_W)
  ) u_mux (
    .line      (line_reg),
    .be        (be_reg),
    .cnt       (cnt_reg),
    .rd_stb    (rd_stb),
    .beat_data (m_axi_wdata),
    .beat_strb (m_axi_wstrb),
    .slice_we  (slice_we)
  );

  // Both bursts share the latched, line-aligned address
  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = BURST_LEN;
  assign m_axi_awsize  = BURST_SIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = BURST_LEN;
  assign m_axi_arsize  = BURST_SIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_wlast   = wvalid_reg && (cnt_reg == LAST_CNT);
  assign m_axi_rready  = rready_reg;
  assign req_ready_o   = ready_reg;
  assign ack_o         = ack_reg;
  assign err_o         = err_reg;

  // Each read slice only changes when its own beat arrives, so data_o holds between reads
  genvar gi;
  for (gi = 0; gi < BEATS; gi++) begin : g_rd_slice
    always_ff @(posedge clk) begin
      if (rst) begin
        rslice_reg[gi] <= '0;
      end else if (slice_we[gi]) begin
        rslice_reg[gi] <= m_axi_rdata;
      end
    end
    assign data_o[gi*AXI_DW +: AXI_DW] = rslice_reg[gi];
  end

`ifdef AXI_LINE_BRIDGE_BRESP_EN
  logic bready_reg;
  assign m_axi_bready = bready_reg;
  logic unused_sigs;
  assign unused_sigs = ^{m_axi_rid, m_axi_bid, req_addr_i[OFF_W-1:0]};
`else
  assign m_axi_bready = 1'b1;
  logic unused_sigs;
  assign unused_sigs = ^{m_axi_rid, m_axi_bid, m_axi_bresp, m_axi_bvalid,
                         req_addr_i[OFF_W-1:0]};
`endif

  // Request sequencing: every handshake output is a register updated with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_INIT;
      addr_reg    <= '0;
      line_reg    <= '0;
      be_reg      <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      arvalid_reg <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      rready_reg  <= 1'b0;
`ifdef AXI_LINE_BRIDGE_BRESP_EN
      bready_reg  <= 1'b0;
`endif
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          if (calib_i) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_rd_i || req_we_i) begin
            addr_reg  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            line_reg  <= req_data_i;
            be_reg    <= req_be_i;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            // A simultaneous write is dropped in favour of the read
            if (req_rd_i) begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RD_A;
            end else begin
              awvalid_reg <= 1'b1;
              state_reg   <= ST_WR_A;
            end
          end
        end
        ST_RD_A: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (m_axi_rvalid) begin
            if (m_axi_rresp != RESP_OKAY) err_reg <= 1'b1;
            if (m_axi_rlast != (cnt_reg == LAST_CNT)) err_reg <= 1'b1;
            // Saturate past the last slice while draining an over-long burst
            if (cnt_reg != PAST_CNT) cnt_reg <= cnt_reg + 1'b1;
            if (m_axi_rlast) begin
              rready_reg <= 1'b0;
              ack_reg    <= 1'b1;
              state_reg  <= ST_DONE;
            end
          end
        end
        ST_WR_A: begin
          if (m_axi_awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b1;
            state_reg   <= ST_WR_D;
          end
        end
        ST_WR_D: begin
          if (m_axi_wready) begin
            if (cnt_reg == LAST_CNT) begin
              wvalid_reg <= 1'b0;
`ifdef AXI_LINE_BRIDGE_BRESP_EN
              bready_reg <= 1'b1;
              state_reg  <= ST_WR_B;
`else
              ack_reg    <= 1'b1;
              state_reg  <= ST_DONE;
`endif
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
`ifdef AXI_LINE_BRIDGE_BRESP_EN
        ST_WR_B: begin
          if (m_axi_bvalid) begin
            bready_reg <= 1'b0;
            if (m_axi_bresp != RESP_OKAY) err_reg <= 1'b1;
            ack_reg    <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

endmodule
